// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared widths, FSM state and fetch-buffer entry type for ifetch.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    // Limit a decode consume request to what the buffer holds; 3 counts as 2.
    function automatic logic [1:0] clamp_pop(
        input logic [1:0] take,
        input logic       has1,
        input logic       has2
    );
        logic [1:0] sat;
        sat = (take == 2'd3) ? 2'd2 : take;
        if (!has1) begin
            return 2'd0;
        end else if (!has2 && (sat != 2'd0)) begin
            return 2'd1;
        end
        return sat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Brief    : Circular fetch buffer, one write port, reads at head and head+1.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  entry_t           wr_data,
    input  logic [1:0]       pop,
    output entry_t           rd0,
    output entry_t           rd1,
    output logic [CNT_W-1:0] count
);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_head1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            r_head  <= r_head + PTR_W'(pop);
            r_count <= r_count - CNT_W'(pop) + CNT_W'(push);
        end
    end

    // Storage is not reset: slot data is only meaningful while count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    assign w_head1 = r_head + PTR_W'(1);
    assign rd0     = r_mem[r_head];
    assign rd1     = r_mem[w_head1];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl
// Brief    : Instruction-fetch sequencer feeding a dual-issue decode stage.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W    = ifetch_pkg::ADDR_W,
    parameter int DATA_W    = ifetch_pkg::DATA_W,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] icache_a,
    input  logic [DATA_W-1:0] icache_rd,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [1:0]        dec_take,
    output logic              out_valid0,
    output logic              out_valid1,
    output logic [DATA_W-1:0] out_inst0,
    output logic [DATA_W-1:0] out_inst1,
    output logic [ADDR_W-1:0] out_pc0,
    output logic [ADDR_W-1:0] out_pc1
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  w_fetch_pc_next;
    logic               w_push;
    logic               w_clear;
    logic [1:0]         w_pop;
    logic [1:0]         w_pop_clamped;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_after_pop;
    logic               w_has1;
    logic               w_has2;
    entry_t             w_wr_entry;
    entry_t             w_rd0;
    entry_t             w_rd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    assign w_has1            = (w_count != '0);
    assign w_has2            = (w_count > CNT_W'(1));
    assign w_pop_clamped     = clamp_pop(dec_take, w_has1, w_has2);
    assign w_count_after_pop = w_count - CNT_W'(w_pop_clamped);

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        w_pop           = 2'd0;
        w_clear         = 1'b0;
        case (r_state)
            // Guard cycle: the ROM image is only valid once reset has fallen.
            IDLE: begin
                w_state_next = RUN;
                if (redirect_valid) begin
                    w_fetch_pc_next = redirect_pc;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    w_clear         = 1'b1;
                    w_fetch_pc_next = redirect_pc;
                end else begin
                    w_pop  = w_pop_clamped;
                    w_push = (w_count_after_pop < CNT_W'(BUF_DEPTH));
                    if (w_push) begin
                        w_fetch_pc_next = r_fetch_pc + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_wr_entry.pc   = r_fetch_pc;
    assign w_wr_entry.inst = icache_rd;

    ifetch_fifo #(
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .push    (w_push),
        .wr_data (w_wr_entry),
        .pop     (w_pop),
        .rd0     (w_rd0),
        .rd1     (w_rd1),
        .count   (w_count)
    );

    assign icache_a   = r_fetch_pc;
    assign out_valid0 = w_has1;
    assign out_valid1 = w_has2;
    assign out_inst0  = w_rd0.inst;
    assign out_inst1  = w_rd1.inst;
    assign out_pc0    = w_rd0.pc;
    assign out_pc1    = w_rd1.pc;

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sequences the single-port, combinational-read instruction ROM (`icache`: 8-bit word address in, 32-bit instruction out) and feeds the dual-issue decode stage. It reads one word per cycle into a small circular fetch buffer and presents the two oldest entries as issue slots 0 and 1. It accepts a 0/1/2-instruction consume from decode each cycle and handles branch/jump redirects by flushing the buffer and restarting fetch at the target.

## Interface
- `ADDR_W`, 8, instruction word-address width (matches ROM index).
- `DATA_W`, 32, instruction width.
- `BUF_DEPTH`, 4, fetch buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `icache_a` out ADDR_W: ROM read address, equal to `fetch_pc` at all times.
- `icache_rd` in DATA_W: ROM read data, combinational from `icache_a`.
- `redirect_valid` in 1: flush request from execute.
- `redirect_pc` in ADDR_W: restart word address.
- `dec_take` in 2: entries consumed this cycle (0, 1, 2); 3 is treated as 2.
- `out_valid0` out 1: slot 0 holds an entry.
- `out_valid1` out 1: slot 1 holds an entry.
- `out_inst0` out DATA_W: slot 0 instruction.
- `out_inst1` out DATA_W: slot 1 instruction.
- `out_pc0` out ADDR_W: slot 0 word address.
- `out_pc1` out ADDR_W: slot 1 word address.

## Operation
- States: IDLE, RUN.
- Reset state: IDLE. `fetch_pc`=0. Head, tail and `count` are 0. All out_valid are 0. `icache_a`=0.
- IDLE:
  - No fetch. This guard cycle exists because ROM contents are loaded when reset falls.
  - Next cycle goes to RUN unless `reset` is high.
  - A `redirect_valid` seen in IDLE loads `fetch_pc`.
- `pop = min(dec_take, count)`: the clamp makes over-consume impossible.
- Push in RUN:
  - `push = (count − pop) < BUF_DEPTH`.
  - On push, write {`fetch_pc`, `icache_rd`} at tail, advance tail, and set `fetch_pc <= fetch_pc + 1`.
  - `fetch_pc` wraps modulo 2^ADDR_W (255 → 0).
- `count_next = count − pop + push`. Head advances by `pop`. Pointers wrap modulo BUF_DEPTH.
- Redirect (highest priority, RUN):
  - On `redirect_valid`: `count`, head and tail go to 0, and `fetch_pc <= redirect_pc`.
  - No push and no pop that cycle; `dec_take` is ignored.
  - Next cycle fetches `redirect_pc`.
- Output slots:
  - `out_valid0 = (count ≥ 1)`; slot 0 = entry[head].
  - `out_valid1 = (count ≥ 2)`; slot 1 = entry[head+1].
  - Outputs are driven from registered buffer contents only. No path from `icache_rd` or `dec_take` to any output.
- Invalid slot data is don't-care; the bench checks it only when the matching valid is 1.
- `reset` asserted at any time, including mid-redirect or with a full buffer, returns to the reset state on the next edge.

## Timing
- Fetch-to-output latency: 1 cycle. A word fetched in cycle N is visible in a slot in cycle N+1 at the earliest.
- Fetch bandwidth: 1 word/cycle. Decode may drain 2/cycle, so the buffer then drains toward 0–1 entries.
- Reset deasserted before edge 0:
  - Cycle 0: IDLE.
  - Cycle 1: fetch pc 0.
  - Cycle 2: `out_valid0`=1 (pc 0); fetch pc 1.
  - Cycle 3: both valid (pc 0, 1) if not consumed.
- Full buffer with `pop`=1 or 2: a push still occurs in the same cycle.
- Full buffer with `pop`=0: no push, and `fetch_pc` holds.
- Redirect in cycle N: outputs invalid in N+1; `out_pc0 = redirect_pc` in N+2.

## Structure
- Package `ifetch_pkg`:
  - `ADDR_W`, `DATA_W`.
  - State enum {IDLE, RUN}.
  - Entry struct {pc, inst}.
- Sub-module `ifetch_fifo`: one write port, two read ports at head and head+1, plus clear, push and pop[1:0]. It owns the pointers and the count.
- `ifetch_ctrl` owns the FSM, `fetch_pc`, the push/redirect decisions and the pop clamp.

## Test plan
- Reset release, ROM word k = k+0x100, `dec_take`=0:
  - Slots show pc0/0x100 from cycle 2, and pc1/0x101 from cycle 3.
  - Count saturates at 4; `icache_a` holds at 4.
- Steady `dec_take`=2 from cycle 2:
  - Every consumed pair is consecutive in pc, with no gaps or duplicates.
  - `out_valid1` is never 1 when count<2.
- Full buffer (pc0–3) with `dec_take`=1: pc4 is pushed the same cycle; next slots are pc1/pc2 and count stays 4.
- Redirect to 0x40 with buffer full and `dec_take`=2 in the same cycle:
  - Next cycle both valid = 0.
  - Following cycle slot0 = pc 0x40; no pre-redirect entry ever reappears.
- Redirect to 0xFE, free-run: fetch sequence 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Reset asserted mid-run with count=3: next cycle all valid=0, `icache_a`=0, state IDLE; the power-up sequence repeats.
